pc_fetch_sequencer: RTL

- Consumer end of the next-PC interface: holds the architectural PC register and loads NextPC from next-PC logic when the core commits.
- Fetches the instruction at CurrentPC from instruction memory over a valid/ready request plus valid response handshake.
- Presents the fetched instruction to decode with a valid flag.
- Detects a misaligned NextPC and a memory response timeout, and parks in a sticky fault state.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/pc_fetch_sequencer_if.sv | 11 +
 rtl/fetch_timeout_counter.sv | 17 +
 rtl/pc_fetch_sequencer.sv | 52 +++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM state encoding and PC alignment helper for the fetch sequencer.
package fetch_pkg;
   localparam int INSTR_W = 32;
   localparam int PC_W = 64;
   localparam logic [1:0] ALIGN_MASK = 2'b11;
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      FAULT = 2'd3
   } state_t;
   function automatic logic aligned(input logic [PC_W-1:0] pc);
      return (pc[1:0] & ALIGN_MASK) == 2'b00;
   endfunction
endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if: instruction memory request/response bus between the sequencer and memory.
interface pc_fetch_sequencer_if;
   import fetch_pkg::*;
   logic req_valid;
   logic req_ready;
   logic [PC_W-1:0] addr;
   logic rsp_valid;
   logic [INSTR_W-1:0] rsp_data;
   modport master (output req_valid, addr, input req_ready, rsp_valid, rsp_data);
   modport slave (input req_valid, addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_timeout_counter.sv
// fetch_timeout_counter: saturating 8-bit wait counter flagging expiry at TIMEOUT-1.
module fetch_timeout_counter #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   logic [7:0] cnt;
   always_ff @(posedge clk) begin
      if (reset || clear) cnt <= '0;
      else if (enable && cnt != 8'hFF) cnt <= cnt + 8'd1;
   end
   assign expired = cnt == 8'(TIMEOUT - 1);
endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the architectural PC, fetches the instruction at it and hands it to decode.
module pc_fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [PC_W-1:0]      next_pc,
   input  logic                 commit,
   output logic [PC_W-1:0]      current_pc,
   pc_fetch_sequencer_if.master imem,
   output logic [INSTR_W-1:0]   instruction,
   output logic                 instr_valid,
   output logic                 fetch_fault
);
   state_t state, state_n;
   logic expired;
   fetch_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (state == FETCH && imem.req_ready),
      .enable (state == WAIT && !imem.rsp_valid),
      .expired(expired)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         current_pc <= RESET_PC;
         instruction <= '0;
      end else begin
         state <= state_n;
         if (state == WAIT && imem.rsp_valid) instruction <= imem.rsp_data;
         // a misaligned target is still loaded so the bad PC is visible in FAULT
         if (state == HOLD && commit) current_pc <= next_pc;
      end
   end
   always_comb begin
      state_n = state;
      case (state)
         FETCH:   state_n = imem.req_ready ? WAIT : FETCH;
         WAIT:    state_n = imem.rsp_valid ? HOLD : (expired ? FAULT : WAIT);
         HOLD:    state_n = commit ? (aligned(next_pc) ? FETCH : FAULT) : HOLD;
         default: state_n = FAULT;
      endcase
   end
   assign imem.req_valid = state == FETCH;
   assign imem.addr = current_pc;
   assign instr_valid = state == HOLD;
   assign fetch_fault = state == FAULT;
endmodule
